// File: rtl/serial_ripple_subtractor.sv
// Bit-serial N-bit subtractor: D = A - B - Bin, one full-subtractor cell and a
// borrow flop, LSB first, with a start/busy/done handshake and held results.
module serial_ripple_subtractor #(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [N-1:0] A_i,
  input  logic [N-1:0] B_i,
  input  logic         Bin_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] D_o,
  output logic         Bout_o,
  output logic         V_o
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_sh_q, a_sh_d;
  logic [N-1:0]  b_sh_q, b_sh_d;
  logic [N-1:0]  res_q, res_d;
  logic [N-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bw_q, bw_d;
  logic          bout_q, bout_d;
  logic          v_q, v_d;

  logic a_s, b_s, d_s, bw_nxt_s;
  logic [N-1:0] res_shift_s;

  // Full-subtractor cell on the current LSBs, and the next-state / datapath logic
  always_comb begin
    a_s         = a_sh_q[0];
    b_s         = b_sh_q[0];
    d_s         = a_s ^ b_s ^ bw_q;
    bw_nxt_s    = (~a_s & b_s) | (~(a_s ^ b_s) & bw_q);
    res_shift_s = {d_s, res_q[N-1:1]};

    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    bw_d    = bw_q;
    bout_d  = bout_q;
    v_d     = v_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          a_sh_d  = A_i;
          b_sh_d  = B_i;
          bw_d    = Bin_i;
          cnt_d   = {CW{1'b0}};
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_sh_d = {1'b0, a_sh_q[N-1:1]};
        b_sh_d = {1'b0, b_sh_q[N-1:1]};
        res_d  = res_shift_s;
        bw_d   = bw_nxt_s;
        if (cnt_q == LAST_BIT) begin
          // On the MSB step a_s/b_s/d_s are the sign bits needed for overflow
          state_d = S_DONE;
          d_d     = res_shift_s;
          bout_d  = bw_nxt_s;
          v_d     = (a_s ^ b_s) & (d_s ^ a_s);
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = S_RUN;
          cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_sh_q  <= {N{1'b0}};
      b_sh_q  <= {N{1'b0}};
      res_q   <= {N{1'b0}};
      d_q     <= {N{1'b0}};
      cnt_q   <= {CW{1'b0}};
      bw_q    <= 1'b0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      bw_q    <= bw_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
    end
  end

  assign busy_o = (state_q == S_RUN);
  assign done_o = (state_q == S_DONE);
  assign D_o    = d_q;
  assign Bout_o = bout_q;
  assign V_o    = v_q;

endmodule
